// File: rtl/mux4_scan_pkg.sv
// rtl/mux4_scan_pkg.sv - shared state encodings and channel constants for the scanner
package mux4_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_CH = 4;
  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - dwell counter with synchronous clear and terminal count at DWELL-1
module dwell_counter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mux4_1.sv
// rtl/mux4_1.sv - combinational 4:1 multiplexer scanned by mux4_scan
module mux4_1 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic [1:0] s,
  output logic       out
);

  always_comb begin
    out = a;
    case (s)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/mux4_scan.sv
// rtl/mux4_scan.sv - steps a 4:1 mux select through all channels and captures one bit per channel
module mux4_scan
  import mux4_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] sample_q, sample_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       cnt_clr;
  logic       cnt_en;
  logic       cnt_tc;

  dwell_counter #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Outputs are computed one cycle ahead so valid/busy/sel come straight from flops.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d = 2'd0;
        if (start) begin
          state_d = ST_SCAN;
          busy_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        cnt_en  = 1'b1;
        cnt_clr = cnt_tc;
        busy_d  = 1'b1;
        if (cnt_tc) begin
          shadow_d[sel_q] = mux_out;
          if (sel_q == LAST_CH) begin
            state_d  = ST_DONE;
            sample_d = shadow_d;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        sel_d = 2'd0;
        if (start) begin
          state_d = ST_SCAN;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'd0;
      shadow_q <= 4'b0000;
      sample_q <= 4'b0000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign sel    = sel_q;
  assign sample = sample_q;
  assign valid  = valid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mux4_scan.sv
// tb/tb_mux4_scan.sv - self-checking bench for mux4_scan at DWELL=4 and DWELL=1
module tb_mux4_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] vec0, vec1;
  logic       mux0_out, mux1_out;
  logic [1:0] sel0, sel1;
  logic [3:0] sample0, sample1;
  logic       valid0, valid1, busy0, busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_1 u_mux0 (.a(vec0[0]), .b(vec0[1]), .c(vec0[2]), .d(vec0[3]), .s(sel0), .out(mux0_out));
  mux4_1 u_mux1 (.a(vec1[0]), .b(vec1[1]), .c(vec1[2]), .d(vec1[3]), .s(sel1), .out(mux1_out));

  mux4_scan #(.DWELL(4), .CNT_W(3)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .mux_out(mux0_out),
    .sel(sel0), .sample(sample0), .valid(valid0), .busy(busy0)
  );

  mux4_scan #(.DWELL(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .mux_out(mux1_out),
    .sel(sel1), .sample(sample1), .valid(valid1), .busy(busy1)
  );

  // Reference: a scan is a position t in 0..4*D-1; channel = t/D, sampled when t%D == D-1.
  int         dw[2] = '{4, 1};
  int         m_t[2];
  bit         m_scan[2];
  bit         m_done[2];
  logic [3:0] m_acc[2];
  logic [3:0] m_sample[2];

  function automatic logic [1:0] m_sel(input int i);
    if (m_scan[i]) return 2'(m_t[i] / dw[i]);
    if (m_done[i]) return 2'd3;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] v[2];
    int ch;
    v[0] = vec0;
    v[1] = vec1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_scan[i] = 0; m_done[i] = 0; m_t[i] = 0; m_acc[i] = '0; m_sample[i] = '0;
      end else if (!m_scan[i]) begin
        m_done[i] = 0;
        if (start) begin
          m_scan[i] = 1; m_t[i] = 0; m_acc[i] = '0;
        end
      end else begin
        ch = m_t[i] / dw[i];
        if (m_t[i] % dw[i] == dw[i] - 1) m_acc[i][ch] = v[i][ch];
        if (m_t[i] == 4 * dw[i] - 1) begin
          m_scan[i] = 0; m_done[i] = 1; m_sample[i] = m_acc[i];
        end else begin
          m_t[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("model_sel0",    32'(sel0),    32'(m_sel(0)));
    chk("model_busy0",   32'(busy0),   32'(m_scan[0]));
    chk("model_valid0",  32'(valid0),  32'(m_done[0]));
    chk("model_sample0", 32'(sample0), 32'(m_sample[0]));
    chk("model_sel1",    32'(sel1),    32'(m_sel(1)));
    chk("model_busy1",   32'(busy1),   32'(m_scan[1]));
    chk("model_valid1",  32'(valid1),  32'(m_done[1]));
    chk("model_sample1", 32'(sample1), 32'(m_sample[1]));
  endtask

  initial begin
    int fv0, fv1, nb, nv, v1c, v2c;
    logic [3:0] s2;

    reset = 1'b1; start = 1'b0; vec0 = '0; vec1 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_sel", 32'(sel0), 32'd0);
    chk("rst_sample", 32'(sample0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);

    // Basic scan (DWELL=4) and minimum dwell (DWELL=1) from the same start pulse
    vec0 = 4'b1101; vec1 = 4'b0110;
    start = 1'b1; tick(); start = 1'b0;
    fv0 = -1; fv1 = -1; nb = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy0) nb++;
      if (valid0 && fv0 < 0) fv0 = c;
      if (valid1 && fv1 < 0) fv1 = c;
      if (c <= 16) chk("basic_sel_step", 32'(sel0), 32'((c - 1) / 4));
      tick();
    end
    chk("basic_busy_cycles", 32'(nb), 32'd16);
    chk("basic_valid_cycle", 32'(fv0), 32'd17);
    chk("basic_sample", 32'(sample0), 32'b1101);
    chk("mindwell_valid_cycle", 32'(fv1), 32'd5);
    chk("mindwell_sample", 32'(sample1), 32'b0110);

    // Start re-pulsed mid-scan is ignored
    start = 1'b1; tick(); start = 1'b0;
    nv = 0; fv0 = -1;
    for (int c = 1; c <= 25; c++) begin
      if (valid0) begin nv++; if (fv0 < 0) fv0 = c; end
      start = (c == 6);
      tick();
    end
    start = 1'b0;
    chk("ignore_valid_count", 32'(nv), 32'd1);
    chk("ignore_valid_cycle", 32'(fv0), 32'd17);

    // Back-to-back scans with start held high
    vec0 = 4'b1101;
    start = 1'b1; tick();
    nv = 0; v1c = -1; v2c = -1; s2 = 'x;
    for (int c = 1; c <= 40; c++) begin
      if (valid0) begin
        nv++;
        if (nv == 1) begin v1c = c; vec0 = 4'b1000; end
        else if (nv == 2) begin v2c = c; s2 = sample0; end
      end
      tick();
    end
    start = 1'b0;
    chk("b2b_first_valid", 32'(v1c), 32'd17);
    chk("b2b_period", 32'(v2c - v1c), 32'd17);
    chk("b2b_second_sample", 32'(s2), 32'b1000);
    for (int c = 0; c < 20; c++) tick();

    // Reset mid-scan at cycle 9
    vec0 = 4'($urandom);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_sample", 32'(sample0), 32'd0);
    chk("midrst_valid", 32'(valid0), 32'd0);
    chk("midrst_sel", 32'(sel0), 32'd0);
    nv = 0;
    for (int c = 0; c < 20; c++) begin if (valid0) nv++; tick(); end
    chk("midrst_no_valid", 32'(nv), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    fv0 = -1;
    for (int c = 1; c <= 20; c++) begin
      if (valid0 && fv0 < 0) fv0 = c;
      tick();
    end
    chk("post_rst_valid_cycle", 32'(fv0), 32'd17);
    chk("post_rst_sample", 32'(sample0), 32'(vec0));

    // Reset and start at the same edge: reset wins
    reset = 1'b1; start = 1'b1; tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy0), 32'd0);
    tick();
    chk("rst_start_busy_next", 32'(busy0), 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(7) == 0);
      reset = ($urandom_range(199) == 0);
      if ($urandom_range(15) == 0) vec0 = 4'($urandom);
      if ($urandom_range(15) == 0) vec1 = 4'($urandom);
      tick();
    end
    reset = 1'b0; start = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
